// File: rtl/ia_addr_pkg.sv
// Shared types for the input-activation address sequencer.
//   state_t    : sequencer FSM encoding
//   MODE_BCAST : every channel receives each word
//   MODE_RR    : words are dealt to channels in turn
package ia_addr_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_DELIVER = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   localparam logic MODE_BCAST = 1'b0;
   localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/ia_addr_channel_reg.sv
// One consumer channel: holds a row/col address word pair and its valid flag.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   load         : capture row_in/col_in and raise valid
//   clear        : drop valid without touching the data (run cancelled)
//   ready        : consumer accept; valid falls on valid & ready
//   row_q/col_q  : held word pair, kept after the handshake
//   valid        : data valid towards the consumer
module ia_addr_channel_reg #(
   parameter int ROW_W = 2304,
   parameter int COL_W = 2560
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             clear,
   input  logic             ready,
   input  logic [ROW_W-1:0] row_in,
   input  logic [COL_W-1:0] col_in,
   output logic [ROW_W-1:0] row_q,
   output logic [COL_W-1:0] col_q,
   output logic             valid
);

   always_ff @(posedge clock) begin
      if (reset) begin
         row_q <= '0;
         col_q <= '0;
         valid <= 1'b0;
      end else begin
         // A cancelled run must leave the previous word in place.
         if (load && !clear) begin
            row_q <= row_in;
            col_q <= col_in;
         end
         if (clear)
            valid <= 1'b0;
         else if (load)
            valid <= 1'b1;
         else if (valid && ready)
            valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ia_addr_sequencer.sv
// Walks a wrapping range of the row/col address BRAMs and hands each word
// pair to NUM_CH consumer channels, broadcast or round-robin, with
// per-channel valid/ready back-pressure.
//   clock, reset             : rising-edge clock, synchronous active-high reset
//   start, abort             : begin a run (IDLE only) / cancel a run
//   mode, base_addr, word_count : run setup, sampled with start
//   ram_en, ram_addr         : shared BRAM read port (1-cycle latency)
//   row_ram_data, col_ram_data : BRAM read data
//   row_addr_out, col_addr_out : per-channel words, channel i at [i*W +: W]
//   out_valid, out_ready     : per-channel handshake
//   busy, done               : run in progress / end-of-run pulse
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for start
// ST_ISSUE   | BRAM read of cur_addr
// ST_CAPTURE | BRAM data valid, load target channel registers
// ST_DELIVER | waiting for every target channel to handshake
// ST_DONE    | one-cycle done pulse
module ia_addr_sequencer
   import ia_addr_pkg::*;
#(
   parameter int ROW_W  = 2304,
   parameter int COL_W  = 2560,
   parameter int NUM_CH = 4,
   parameter int DEPTH  = 32,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    abort,
   input  logic                    mode,
   input  logic [AW-1:0]           base_addr,
   input  logic [AW:0]             word_count,
   output logic                    ram_en,
   output logic [AW-1:0]           ram_addr,
   input  logic [ROW_W-1:0]        row_ram_data,
   input  logic [COL_W-1:0]        col_ram_data,
   output logic [NUM_CH*ROW_W-1:0] row_addr_out,
   output logic [NUM_CH*COL_W-1:0] col_addr_out,
   output logic [NUM_CH-1:0]       out_valid,
   input  logic [NUM_CH-1:0]       out_ready,
   output logic                    busy,
   output logic                    done
);

   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   state_t            state;
   logic [AW-1:0]     cur_addr;
   logic [AW-1:0]     last_addr;
   logic [AW:0]       remaining;
   logic              mode_q;
   logic [CW-1:0]     ch_idx;
   logic [NUM_CH-1:0] load_ch;
   logic              clear_ch;
   logic              word_done;

   // ram_addr follows cur_addr only while reading; otherwise it holds the
   // address of the last read so the BRAM port stays quiet.
   assign ram_en   = (state == ST_ISSUE);
   assign ram_addr = ram_en ? cur_addr : last_addr;

   assign clear_ch  = abort && (state != ST_IDLE);
   assign word_done = &(~out_valid | out_ready);

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         cur_addr  <= '0;
         last_addr <= '0;
         remaining <= '0;
         mode_q    <= MODE_BCAST;
         ch_idx    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort && (state != ST_IDLE)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     cur_addr  <= base_addr;
                     remaining <= word_count;
                     mode_q    <= mode;
                     ch_idx    <= '0;
                     busy      <= 1'b1;
                     if (word_count == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                     end else begin
                        state <= ST_ISSUE;
                     end
                  end
               end
               ST_ISSUE: begin
                  last_addr <= cur_addr;
                  state     <= ST_CAPTURE;
               end
               ST_CAPTURE: begin
                  state <= ST_DELIVER;
               end
               ST_DELIVER: begin
                  if (word_done) begin
                     remaining <= remaining - (AW+1)'(1);
                     // DEPTH is a power of two, so the add wraps naturally.
                     cur_addr  <= cur_addr + AW'(1);
                     ch_idx    <= (ch_idx == CW'(NUM_CH-1)) ? '0 : ch_idx + CW'(1);
                     if (remaining > (AW+1)'(1)) begin
                        state <= ST_ISSUE;
                     end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                     end
                  end
               end
               ST_DONE: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign load_ch[i] = (state == ST_CAPTURE) &&
                          ((mode_q == MODE_BCAST) || (ch_idx == CW'(i)));

      ia_addr_channel_reg #(
         .ROW_W (ROW_W),
         .COL_W (COL_W)
      ) u_ch (
         .clock  (clock),
         .reset  (reset),
         .load   (load_ch[i]),
         .clear  (clear_ch),
         .ready  (out_ready[i]),
         .row_in (row_ram_data),
         .col_in (col_ram_data),
         .row_q  (row_addr_out[i*ROW_W +: ROW_W]),
         .col_q  (col_addr_out[i*COL_W +: COL_W]),
         .valid  (out_valid[i])
      );
   end

endmodule

// File: tb/tb_ia_addr_sequencer.sv
// Directed bench for ia_addr_sequencer with a BRAM model and a scoreboard of
// expected BRAM reads and channel deliveries.
module tb_ia_addr_sequencer;

   localparam int ROW_W  = 64;
   localparam int COL_W  = 72;
   localparam int NUM_CH = 4;
   localparam int DEPTH  = 32;
   localparam int AW     = 5;
   localparam int BIG    = 512;

   typedef struct {
      logic [AW-1:0]     addr;
      logic [NUM_CH-1:0] mask;
   } exp_t;

   logic                    clock = 1'b0;
   logic                    reset = 1'b1;
   logic                    start = 1'b0;
   logic                    abort = 1'b0;
   logic                    mode  = 1'b0;
   logic [AW-1:0]           base_addr  = '0;
   logic [AW:0]             word_count = '0;
   logic                    ram_en;
   logic [AW-1:0]           ram_addr;
   logic [ROW_W-1:0]        row_ram_data = '0;
   logic [COL_W-1:0]        col_ram_data = '0;
   logic [NUM_CH*ROW_W-1:0] row_addr_out;
   logic [NUM_CH*COL_W-1:0] col_addr_out;
   logic [NUM_CH-1:0]       out_valid;
   logic [NUM_CH-1:0]       out_ready = '0;
   logic                    busy;
   logic                    done;

   int checks = 0;
   int errors = 0;

   logic [AW-1:0]     addr_q[$];
   exp_t              word_q[$];
   logic [NUM_CH-1:0] prev_valid = '0;
   exp_t              mon_e;

   ia_addr_sequencer #(
      .ROW_W  (ROW_W),
      .COL_W  (COL_W),
      .NUM_CH (NUM_CH),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .abort        (abort),
      .mode         (mode),
      .base_addr    (base_addr),
      .word_count   (word_count),
      .ram_en       (ram_en),
      .ram_addr     (ram_addr),
      .row_ram_data (row_ram_data),
      .col_ram_data (col_ram_data),
      .row_addr_out (row_addr_out),
      .col_addr_out (col_addr_out),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .busy         (busy),
      .done         (done)
   );

   always #5 clock = ~clock;

   function automatic logic [ROW_W-1:0] row_word(input logic [AW-1:0] a);
      return {32'hABCD_0000 | 32'(a), 32'h1234_5600 ^ 32'(a)};
   endfunction

   function automatic logic [COL_W-1:0] col_word(input logic [AW-1:0] a);
      return {8'hC5, 32'hFEED_0000 | 32'(a), 32'h0BAD_F000 + 32'(a) * 32'd3};
   endfunction

   // BRAM model, one-cycle read latency
   always @(posedge clock) begin
      if (ram_en) begin
         row_ram_data <= row_word(ram_addr);
         col_ram_data <= col_word(ram_addr);
      end
   end

   task automatic chk(input string tag, input logic [BIG-1:0] obs, input logic [BIG-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_run(input logic m, input int base, input int cnt);
      logic [AW-1:0]     a;
      logic [NUM_CH-1:0] msk;
      for (int k = 0; k < cnt; k++) begin
         a   = AW'((base + k) % DEPTH);
         msk = m ? NUM_CH'(1 << (k % NUM_CH)) : {NUM_CH{1'b1}};
         addr_q.push_back(a);
         word_q.push_back('{addr: a, mask: msk});
      end
   endtask

   // Drives start for one edge; returns at the first negedge after acceptance.
   task automatic run_start(input logic m, input int base, input int cnt);
      push_run(m, base, cnt);
      mode       = m;
      base_addr  = AW'(base);
      word_count = (AW+1)'(cnt);
      start      = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("busy_after_start", BIG'(busy), BIG'(1));
   endtask

   // n counts negedges since the start edge, starting at the first one.
   task automatic wait_done(input int exp_lat);
      int n;
      n = 1;
      while (!done && n < 200) begin
         @(negedge clock);
         n++;
      end
      chk("done_seen", BIG'(done), BIG'(1));
      if (exp_lat > 0) chk("done_latency", BIG'(n), BIG'(exp_lat));
      @(negedge clock);
      chk("done_one_cycle", BIG'(done), BIG'(0));
      chk("busy_after_done", BIG'(busy), BIG'(0));
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (out_valid == '0 && n < 50);
      chk("valid_timeout", BIG'(out_valid != '0), BIG'(1));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ram_en"},    BIG'(ram_en),       BIG'(0));
      chk({tag, "_ram_addr"},  BIG'(ram_addr),     BIG'(0));
      chk({tag, "_out_valid"}, BIG'(out_valid),    BIG'(0));
      chk({tag, "_busy"},      BIG'(busy),         BIG'(0));
      chk({tag, "_done"},      BIG'(done),         BIG'(0));
      chk({tag, "_row_out"},   BIG'(row_addr_out), BIG'(0));
      chk({tag, "_col_out"},   BIG'(col_addr_out), BIG'(0));
   endtask

   // Scoreboard monitor: BRAM reads and each newly presented word.
   always @(negedge clock) begin
      if (!reset) begin
         if (ram_en) begin
            if (addr_q.size() == 0) chk("ram_en_unexpected", BIG'(ram_en), BIG'(0));
            else chk("ram_addr", BIG'(ram_addr), BIG'(addr_q.pop_front()));
         end
         if (out_valid != '0 && prev_valid == '0) begin
            if (word_q.size() == 0) begin
               chk("valid_unexpected", BIG'(out_valid), BIG'(0));
            end else begin
               mon_e = word_q.pop_front();
               chk("out_valid_mask", BIG'(out_valid), BIG'(mon_e.mask));
               for (int i = 0; i < NUM_CH; i++) begin
                  if (mon_e.mask[i]) begin
                     chk("row_data", BIG'(row_addr_out[i*ROW_W +: ROW_W]), BIG'(row_word(mon_e.addr)));
                     chk("col_data", BIG'(col_addr_out[i*COL_W +: COL_W]), BIG'(col_word(mon_e.addr)));
                  end
               end
            end
         end
      end
      prev_valid = out_valid;
   end

   initial begin
      repeat (3) @(negedge clock);
      chk_reset_outputs("reset");
      reset = 1'b0;
      @(negedge clock);

      // broadcast, two words
      out_ready = 4'hF;
      run_start(1'b0, 0, 2);
      wait_done(7);

      // round-robin, six words, then a fresh run restarts at channel 0
      run_start(1'b1, 5, 6);
      wait_done(19);
      run_start(1'b1, 9, 1);
      wait_done(4);

      // address wrap
      run_start(1'b0, 30, 4);
      wait_done(13);

      // back-pressure on channel 3
      out_ready = 4'b0111;
      run_start(1'b0, 3, 2);
      wait_valid();
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         chk("bp_valid", BIG'(out_valid), BIG'(4'b1000));
         chk("bp_ram_en", BIG'(ram_en), BIG'(0));
      end
      out_ready = 4'hF;
      wait_done(0);

      // abort during delivery of the second of four words
      run_start(1'b0, 10, 4);
      wait_valid();
      wait_valid();
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      chk("abort_busy", BIG'(busy), BIG'(0));
      chk("abort_valid", BIG'(out_valid), BIG'(0));
      chk("abort_done", BIG'(done), BIG'(0));
      chk("abort_row_kept", BIG'(row_addr_out[0 +: ROW_W]), BIG'(row_word(5'd11)));
      chk("abort_sb_left", BIG'(word_q.size()), BIG'(2));
      addr_q.delete();
      word_q.delete();
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         chk("abort_no_done", BIG'(done), BIG'(0));
      end
      run_start(1'b0, 20, 1);
      wait_done(4);

      // zero-length run
      run_start(1'b0, 7, 0);
      wait_done(1);

      // reset in the middle of a run
      run_start(1'b0, 0, 8);
      repeat (4) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk_reset_outputs("midrun_reset");
      reset = 1'b0;
      addr_q.delete();
      word_q.delete();
      @(negedge clock);
      run_start(1'b1, 2, 1);
      wait_done(4);

      chk("sb_words_left", BIG'(word_q.size()), BIG'(0));
      chk("sb_reads_left", BIG'(addr_q.size()), BIG'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ia_addr_sequencer.md
# ia_addr_sequencer

Parametrised successor to the input-activation address fetch path. Walks a contiguous, wrapping range of the row/col address BRAMs and delivers each row/col word pair to NUM_CH consumer channels, in broadcast or round-robin mode. Each channel has a valid/ready handshake, so slow convolution lanes back-pressure the fetch. Sits between the row/col address BRAMs and the IA fetch lanes, replacing the fixed 4-way arbiter path.

## Interface
Parameters:
- ROW_W, 2304, row address word width
- COL_W, 2560, col address word width
- NUM_CH, 4, consumer channels (>=1)
- DEPTH, 32, BRAM depth; must be a power of two
- AW, $clog2(DEPTH), BRAM address width

Ports:
- clock  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  synchronous cancel of a run
- mode  in  1  0 = broadcast, 1 = round-robin; sampled with start
- base_addr  in  AW  first BRAM address; sampled with start
- word_count  in  AW+1  number of words to deliver; sampled with start
- ram_en  out  1  BRAM enable, shared by row and col RAMs
- ram_addr  out  AW  BRAM address, shared
- row_ram_data  in  ROW_W  row BRAM douta; 1-cycle read latency
- col_ram_data  in  COL_W  col BRAM douta; 1-cycle read latency
- row_addr_out  out  NUM_CH*ROW_W  channel i at [i*ROW_W +: ROW_W]
- col_addr_out  out  NUM_CH*COL_W  channel i at [i*COL_W +: COL_W]
- out_valid  out  NUM_CH  per-channel data valid
- out_ready  in  NUM_CH  per-channel accept
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at the end of a non-aborted run

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, DELIVER, DONE.
- IDLE: on start, latch mode, base_addr and word_count into cur_addr, remaining and mode_q, and set ch_idx=0.
  - word_count==0 -> DONE.
  - Otherwise -> ISSUE.
- ISSUE: ram_en=1, ram_addr=cur_addr; -> CAPTURE. ram_en is 0 in every other state, and ram_addr holds its last value.
- CAPTURE: load row_ram_data/col_ram_data into the target channel registers and set their out_valid; -> DELIVER.
  - Broadcast: all NUM_CH channels are targets.
  - Round-robin: only channel ch_idx is the target.
- DELIVER: out_valid[i] clears on any edge where out_valid[i]&out_ready[i]. The word completes on the edge where every i satisfies !out_valid[i] | out_ready[i]. On that edge:
  - remaining decrements.
  - cur_addr increments mod DEPTH; wrap from DEPTH-1 to 0 is legal.
  - ch_idx increments mod NUM_CH.
  - Next state is ISSUE if remaining > 1 before decrement, else DONE.
- DONE: done=1 for this cycle only; -> IDLE.
- Channel data registers hold their last value after the handshake and are overwritten only on CAPTURE.
- word_count > DEPTH is legal: addresses keep wrapping and re-read.
- start while busy is ignored.
- abort, any non-IDLE state: next state IDLE, all out_valid cleared, done is not pulsed, data registers are kept. abort takes priority over every transition. abort in IDLE is a no-op, including when start is high in the same cycle.

## Timing
- Reset: state=IDLE, ram_en=0, ram_addr=0, all row_addr_out/col_addr_out=0, out_valid=0, busy=0, done=0, ch_idx=0.
- Start accepted at edge t:
  - ISSUE during cycle t+1.
  - BRAM data present and captured during cycle t+2.
  - out_valid high from cycle t+3.
- With out_ready held high, sustained throughput is one word per 3 cycles (ISSUE, CAPTURE, DELIVER).
- done asserts the cycle after the final handshake edge; busy falls the cycle after done.
- All outputs are registered except ram_en/ram_addr, which are decoded from registered state and cur_addr.

## Structure
- Package ia_addr_pkg: state enum, MODE_BCAST/MODE_RR constants.
- Sub-module ia_addr_channel_reg, generated NUM_CH times: ROW_W+COL_W holding register with load, valid/ready and clear inputs.
- The top level holds the FSM, counters and channel select.

## Test plan
- Broadcast, NUM_CH=4, base=0, count=2, out_ready=4'hF -> ram_addr 0 then 1. All four channels present word0 then word1. done is pulsed 1 cycle, 7 cycles after the start edge.
- Round-robin, count=6 -> channel order 0,1,2,3,0,1, each with the matching BRAM word. Only that channel's out_valid is high for each word.
- Wrap: base=30, count=4, DEPTH=32 -> BRAM reads at addresses 30, 31, 0, 1.
- Back-pressure, broadcast: out_ready=4'b0111 for 5 cycles, then 4'hF. Channels 0-2 clear after one cycle; channel 3 stays valid. No new ram_en until channel 3 handshakes.
- abort during DELIVER of word 2 of 4 -> next cycle state IDLE, out_valid=0, busy=0, no done. A following start runs normally.
- count=0 -> no ram_en, done pulses 1 cycle after start. Reset asserted mid-run -> all outputs return to reset values on the next edge.
